// File: rtl/tt_input_conditioner.sv
// Multi-channel pin conditioner: synchroniser, inversion, debounce, edge pulses, event counter.
// Optional sticky aborted-transition log enabled by defining IC_GLITCH_LOG_EN.

module ic_lane #(
    parameter int SYNC_STAGES   = 2,
    parameter int DEBOUNCE_BITS = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic din,
    input  logic invert,
`ifdef IC_GLITCH_LOG_EN
    input  logic clr,
    output logic glitch,
`endif
    output logic level,
    output logic rise,
    output logic fall
);
    localparam int MAX = (1 << DEBOUNCE_BITS) - 1;
    localparam logic [DEBOUNCE_BITS-1:0] CNT_LAST = DEBOUNCE_BITS'(MAX - 1);

    logic [SYNC_STAGES-1:0]   sync_q;
    logic [DEBOUNCE_BITS-1:0] cnt;
    logic                     s;
    logic                     rise_q;
    logic                     fall_q;

    assign s = sync_q[SYNC_STAGES-1] ^ invert;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
            cnt    <= '0;
            level  <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else if (ena) begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            if (s == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                // MAX-th consecutive mismatch: commit the new level
                level  <= s;
                cnt    <= '0;
                rise_q <= s;
                fall_q <= ~s;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end
    end

    assign rise = rise_q & ena;
    assign fall = fall_q & ena;

`ifdef IC_GLITCH_LOG_EN
    logic glitch_q;

    // set wins over clear so an abort in the clearing cycle is not lost
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            glitch_q <= 1'b0;
        end else if (ena) begin
            if (s == level && cnt != '0) glitch_q <= 1'b1;
            else if (clr)                glitch_q <= 1'b0;
        end
    end

    assign glitch = glitch_q;
`endif
endmodule

module tt_input_conditioner #(
    parameter int WIDTH         = 8,
    parameter int SYNC_STAGES   = 2,
    parameter int DEBOUNCE_BITS = 4,
    localparam int SEL_W        = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [WIDTH-1:0] din,
    input  logic [WIDTH-1:0] invert_mask,
    input  logic [SEL_W-1:0] cnt_sel,
    input  logic             cnt_clr,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [7:0]       evt_cnt,
    output logic [WIDTH-1:0] glitch
);
    logic [2**SEL_W-1:0] rise_ext;

    ic_lane #(
        .SYNC_STAGES  (SYNC_STAGES),
        .DEBOUNCE_BITS(DEBOUNCE_BITS)
    ) u_lane [WIDTH-1:0] (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .din    (din),
        .invert (invert_mask),
`ifdef IC_GLITCH_LOG_EN
        .clr    (cnt_clr),
        .glitch (glitch),
`endif
        .level  (dout),
        .rise   (rise),
        .fall   (fall)
    );

`ifndef IC_GLITCH_LOG_EN
    assign glitch = '0;
`endif

    // zero-padded so selects beyond WIDTH never count
    always_comb begin
        rise_ext             = '0;
        rise_ext[WIDTH-1:0]  = rise;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            evt_cnt <= '0;
        end else if (ena) begin
            if (cnt_clr)
                evt_cnt <= '0;
            else if (rise_ext[cnt_sel] && evt_cnt != 8'hFF)
                evt_cnt <= evt_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_tt_input_conditioner.sv
// Scoreboard bench for tt_input_conditioner: behavioural model pushes expectations, negedge monitor checks.
module tb_tt_input_conditioner;
    localparam int W    = 8;
    localparam int SYNC = 2;
    localparam int MAX  = 15;
`ifdef IC_GLITCH_LOG_EN
    localparam bit GLITCH_EN = 1'b1;
`else
    localparam bit GLITCH_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n, ena, cnt_clr;
    logic [W-1:0] din, invert_mask, dout, rise, fall, glitch;
    logic [2:0]   cnt_sel;
    logic [7:0]   evt_cnt;

    int n_checks = 0;
    int n_err    = 0;

    tt_input_conditioner dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .din(din), .invert_mask(invert_mask),
        .cnt_sel(cnt_sel), .cnt_clr(cnt_clr), .dout(dout), .rise(rise), .fall(fall),
        .evt_cnt(evt_cnt), .glitch(glitch)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    typedef struct {
        logic [W-1:0] dout, rise, fall, glitch;
        logic [7:0]   evt;
    } exp_t;
    exp_t sb_q[$];

    // Reference model: din history as a queue, debounce as a run length of mismatching edges
    logic [W-1:0] hq[$];
    int           run[W];
    logic [W-1:0] m_dout, m_rise, m_fall, m_glitch;
    int           m_evt;

    always @(posedge clk) begin
        logic [W-1:0] so, setg, nr, nf;
        logic         s_i, hit;
        exp_t         e;
        if (!rst_n) begin
            hq.delete();
            repeat (SYNC) hq.push_back('0);
            for (int i = 0; i < W; i++) run[i] = 0;
            m_dout = '0; m_rise = '0; m_fall = '0; m_glitch = '0; m_evt = 0;
        end else if (ena) begin
            so   = hq[0];
            hit  = (int'(cnt_sel) < W) && m_rise[cnt_sel];
            setg = '0; nr = '0; nf = '0;
            for (int i = 0; i < W; i++) begin
                s_i = so[i] ^ invert_mask[i];
                if (s_i != m_dout[i]) begin
                    run[i]++;
                    if (run[i] == MAX) begin
                        m_dout[i] = s_i; run[i] = 0; nr[i] = s_i; nf[i] = ~s_i;
                    end
                end else begin
                    if (run[i] != 0) setg[i] = GLITCH_EN;
                    run[i] = 0;
                end
            end
            void'(hq.pop_front());
            hq.push_back(din);
            m_rise = nr; m_fall = nf;
            if (cnt_clr)                  m_evt = 0;
            else if (hit && m_evt < 255)  m_evt++;
            m_glitch = cnt_clr ? setg : (m_glitch | setg);
        end else begin
            m_rise = '0; m_fall = '0;
        end
        e.dout = m_dout; e.rise = m_rise; e.fall = m_fall; e.glitch = m_glitch; e.evt = 8'(m_evt);
        sb_q.push_back(e);
    end

    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("dout",    32'(dout),    32'(e.dout));
            check("rise",    32'(rise),    32'(e.rise & {W{ena}}));
            check("fall",    32'(fall),    32'(e.fall & {W{ena}}));
            check("evt_cnt", 32'(evt_cnt), 32'(e.evt));
            check("glitch",  32'(glitch),  32'(e.glitch));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic edges_until(input int ch, input logic val, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (dout[ch] !== val && n < 100);
    endtask

    initial begin
        int n, k;
        rst_n = 1'b0; ena = 1'b1; cnt_clr = 1'b0;
        din = 8'hFF; invert_mask = '0; cnt_sel = 3'd0;

        repeat (3) tick();
        check("rst_dout", 32'(dout), 0);
        check("rst_rise", 32'(rise | fall), 0);
        check("rst_evt",  32'(evt_cnt), 0);
        check("rst_glitch", 32'(glitch), 0);

        din = '0;
        tick();
        rst_n = 1'b1;
        repeat (5) tick();

        // clean step on channel 0
        din[0] = 1'b1;
        edges_until(0, 1'b1, n);
        check("step_latency", 32'(n), 17);
        check("step_rise", 32'(rise[0]), 1);
        tick(); tick();
        check("step_evt", 32'(evt_cnt), 1);

        // bounce on channel 1
        for (int t = 0; t < 8; t++) begin
            din[1] = ~din[1];
            repeat (5) tick();
        end
        repeat (20) tick();
        check("bounce_dout", 32'(dout[1]), 0);
`ifdef IC_GLITCH_LOG_EN
        check("bounce_glitch", 32'(glitch[1]), 1);
`else
        check("bounce_glitch", 32'(glitch[1]), 0);
`endif

        // inversion from reset
        rst_n = 1'b0; invert_mask = 8'h04; din = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        edges_until(2, 1'b1, n);
        check("invert_latency", 32'(n), 15);
        check("invert_rise", 32'(rise[2]), 1);
        invert_mask = '0;
        repeat (20) tick();

        // saturating counter on channel 3
        cnt_sel = 3'd3;
        cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
        for (int t = 0; t < 300; t++) begin
            din[3] = 1'b1; repeat (18) tick();
            din[3] = 1'b0; repeat (18) tick();
        end
        check("sat_evt", 32'(evt_cnt), 255);
        din[3] = 1'b1;
        edges_until(3, 1'b1, n);
        check("clr_rise", 32'(rise[3]), 1);
        cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
        check("clr_evt", 32'(evt_cnt), 0);

        // freeze mid-debounce on channel 4
        din[4] = 1'b1;
        repeat (8) tick();
        ena = 1'b0;
        repeat (10) tick();
        ena = 1'b1;
        edges_until(4, 1'b1, n);
        check("freeze_latency", 32'(n + 18), 27);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < W; i++)
                if ($urandom_range(23) == 0) din[i] = ~din[i];
            if ($urandom_range(199) == 0) begin
                k = int'($urandom_range(W - 1));
                invert_mask[k] = ~invert_mask[k];
            end
            if ($urandom_range(49) == 0) cnt_sel = 3'($urandom_range(7));
            cnt_clr = ($urandom_range(39) == 0);
            ena     = ($urandom_range(14) != 0);
            rst_n   = ($urandom_range(499) != 0);
            tick();
        end
        rst_n = 1'b1; ena = 1'b1; cnt_clr = 1'b0;
        repeat (40) tick();

        @(negedge clk);
        #1;
        check("sb_drain", 32'(sb_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
